snapshot_mem_bridge: RTL and testbench



---
 rtl/snapshot_mem_bridge.sv | 168 ++++++++++++++++
 tb/tb_snapshot_mem_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snapshot_mem_bridge.sv
// Width-adapting snapshot bridge between a DATA_WIDTH register bus and a wide external memory.
// Word-select 0 commits (write) or fetches (read) a full entry; other selects hit the shared buffer.
module snapshot_mem_bridge #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 1,
    parameter int MEM_DATA_WIDTH = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      soft_rst,
    input  logic                      req_vld,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      ack_vld,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      mem_req_vld,
    output logic                      mem_wr_en,
    output logic                      mem_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_wr_data,
    input  logic                      mem_ack_vld,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data
);

    localparam int N = MEM_DATA_WIDTH / DATA_WIDTH;
    localparam int B = $clog2(DATA_WIDTH / 8);
    localparam int S = $clog2(N);

    typedef enum logic [1:0] {IDLE, MEM_WR, MEM_RD, ACK} state_e;

    state_e                    state_q, state_d;
    logic [MEM_DATA_WIDTH-1:0] buf_q, buf_d;
    logic                      ack_vld_q, ack_vld_d;
    logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
    logic                      mem_req_vld_q, mem_req_vld_d;
    logic                      mem_wr_en_q, mem_wr_en_d;
    logic                      mem_rd_en_q, mem_rd_en_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;

    logic [S-1:0]              sel;
    logic [MEM_ADDR_WIDTH-1:0] entry;
    logic                      is_wr, is_rd;
    logic                      unused_addr;

    // Write wins when both qualifiers are set.
    always_comb begin
        sel         = addr[B +: S];
        entry       = addr[B+S +: MEM_ADDR_WIDTH];
        is_wr       = wr_en;
        is_rd       = rd_en & ~wr_en;
        unused_addr = ^{addr[ADDR_WIDTH-1:B+S+MEM_ADDR_WIDTH], addr[B-1:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            buf_q         <= '0;
            ack_vld_q     <= 1'b0;
            rd_data_q     <= '0;
            mem_req_vld_q <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            ack_vld_q     <= ack_vld_d;
            rd_data_q     <= rd_data_d;
            mem_req_vld_q <= mem_req_vld_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    if ((is_wr || is_rd) && sel == '0) state_d = is_wr ? MEM_WR : MEM_RD;
                    else                               state_d = ACK;
                end
            end
            MEM_WR, MEM_RD: if (mem_ack_vld) state_d = ACK;
            ACK:            state_d = IDLE;
            default:        state_d = IDLE;
        endcase
        if (soft_rst) state_d = IDLE;
    end

    always_comb begin
        buf_d         = buf_q;
        ack_vld_d     = 1'b0;
        rd_data_d     = '0;
        mem_req_vld_d = 1'b0;
        mem_wr_en_d   = 1'b0;
        mem_rd_en_d   = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    if (is_wr) begin
                        for (int unsigned i = 0; i < N; i++)
                            if (sel == S'(i)) buf_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
                        if (sel == '0) begin
                            mem_wr_data_d = buf_d;
                            mem_addr_d    = entry;
                            mem_req_vld_d = 1'b1;
                            mem_wr_en_d   = 1'b1;
                        end else begin
                            ack_vld_d = 1'b1;
                        end
                    end else if (is_rd && sel == '0) begin
                        mem_addr_d    = entry;
                        mem_req_vld_d = 1'b1;
                        mem_rd_en_d   = 1'b1;
                    end else begin
                        ack_vld_d = 1'b1;
                        if (is_rd)
                            for (int unsigned i = 0; i < N; i++)
                                if (sel == S'(i)) rd_data_d = buf_q[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            MEM_WR: if (mem_ack_vld) ack_vld_d = 1'b1;
            MEM_RD: begin
                if (mem_ack_vld) begin
                    buf_d     = mem_rd_data;
                    rd_data_d = mem_rd_data[DATA_WIDTH-1:0];
                    ack_vld_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (soft_rst) begin
            buf_d         = '0;
            ack_vld_d     = 1'b0;
            rd_data_d     = '0;
            mem_req_vld_d = 1'b0;
            mem_wr_en_d   = 1'b0;
            mem_rd_en_d   = 1'b0;
            mem_addr_d    = '0;
            mem_wr_data_d = '0;
        end
    end

    assign ack_vld     = ack_vld_q;
    assign rd_data     = rd_data_q;
    assign mem_req_vld = mem_req_vld_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;

    // Requests outside IDLE are dropped silently; flag them as a protocol violation.
    req_while_busy: assert property (@(posedge clk) disable iff (rst || soft_rst)
                                     !(req_vld && state_q != IDLE))
        else $warning("snapshot_mem_bridge: req_vld while busy, request dropped");

endmodule

// File: tb/tb_snapshot_mem_bridge.sv
// Directed bench for snapshot_mem_bridge: transaction-level buffer/memory model plus per-cycle output checks.
module tb_snapshot_mem_bridge;

    localparam int AW  = 64;
    localparam int DW  = 32;
    localparam int MAW = 1;
    localparam int MDW = 128;
    localparam int N   = MDW / DW;

    logic           clk = 1'b0;
    logic           rst, soft_rst, req_vld, wr_en, rd_en;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wr_data;
    logic           ack_vld;
    logic [DW-1:0]  rd_data;
    logic           mem_req_vld, mem_wr_en, mem_rd_en;
    logic [MAW-1:0] mem_addr;
    logic [MDW-1:0] mem_wr_data;
    logic           mem_ack_vld;
    logic [MDW-1:0] mem_rd_data;

    snapshot_mem_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW), .MEM_DATA_WIDTH(MDW)
    ) dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .req_vld(req_vld), .wr_en(wr_en),
        .rd_en(rd_en), .addr(addr), .wr_data(wr_data), .ack_vld(ack_vld), .rd_data(rd_data),
        .mem_req_vld(mem_req_vld), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_ack_vld(mem_ack_vld),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [MDW-1:0] mem [2];
    logic [DW-1:0]  mbuf [N];
    logic [DW-1:0]  exp_q [$];

    int             mreq_cnt = 0;
    bit             last_wr;
    int             last_addr;
    logic [MDW-1:0] last_wdata;
    int             mack_cyc = 0;
    bit             mem_auto = 1'b1;
    int             mem_delay = 2;
    bit             stray = 1'b0;
    bit             prev_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [MDW-1:0] act, input logic [MDW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [AW-1:0] mk_addr(input int ent, input int sel);
        return 64'h0000_0100_0000_0000 | (64'(ent) << 4) | (64'(sel) << 2);
    endfunction

    // Memory responder: acknowledges each request after mem_delay cycles.
    initial begin
        mem_ack_vld = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(negedge clk);
            if (stray) begin
                stray       = 1'b0;
                mem_ack_vld = 1'b1;
                mem_rd_data = {4{32'hDEAD_0001}};
                mack_cyc    = cyc;
                @(negedge clk);
                mem_ack_vld = 1'b0;
                mem_rd_data = '0;
            end else if (mem_req_vld && !rst) begin
                mreq_cnt++;
                last_wr    = mem_wr_en;
                last_addr  = int'(mem_addr);
                last_wdata = mem_wr_data;
                if (mem_auto) begin
                    repeat (mem_delay) @(negedge clk);
                    mem_ack_vld = 1'b1;
                    mem_rd_data = last_wr ? '0 : mem[last_addr];
                    mack_cyc    = cyc;
                    if (last_wr) mem[last_addr] = last_wdata;
                    @(negedge clk);
                    mem_ack_vld = 1'b0;
                    mem_rd_data = '0;
                end
            end
        end
    end

    // Per-cycle output checker against the expected-ack queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ack_vld) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_ack: got ack_vld=1 rd_data=%h, want no ack (cycle %0d)", rd_data, cyc);
                    end else begin
                        chk("ack_rd_data", rd_data, exp_q.pop_front());
                    end
                end else begin
                    chk("rd_data_zero_without_ack", rd_data, '0);
                end
                if (prev_req) chk("mem_req_one_cycle", mem_req_vld, '0);
                if (!mem_req_vld) chk("mem_qual_pulse", {mem_wr_en, mem_rd_en}, '0);
            end
            prev_req = mem_req_vld;
        end
    end

    task automatic do_req(input bit wr, input bit rd, input int sel, input int ent,
                          input logic [DW-1:0] data, input bit chk_lit,
                          input logic [DW-1:0] lit, input int inject_at);
        logic [DW-1:0] expd;
        logic [DW-1:0] got;
        bit            memop;
        bit            seen;
        int            m0, rq_cyc, ack_cyc;
        memop = (sel == 0) && (wr || rd);
        if (wr) begin
            mbuf[sel] = data;
            expd      = '0;
        end else if (rd) begin
            if (sel == 0) for (int k = 0; k < N; k++) mbuf[k] = mem[ent][k*DW +: DW];
            expd = mbuf[sel];
        end else begin
            expd = '0;
        end
        exp_q.push_back(expd);
        m0 = mreq_cnt;
        @(negedge clk);
        req_vld = 1'b1; wr_en = wr; rd_en = rd; addr = mk_addr(ent, sel); wr_data = data;
        rq_cyc  = cyc;
        seen = 1'b0; ack_cyc = 0; got = '0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(negedge clk);
            if (i == inject_at) begin
                req_vld = 1'b1; wr_en = 1'b1; rd_en = 1'b0;
                addr = mk_addr(ent, 1); wr_data = 32'hBAD0_BAD0;
            end else begin
                req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
            end
            if (ack_vld) begin
                seen    = 1'b1;
                ack_cyc = cyc;
                got     = rd_data;
            end
        end
        #1;
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL ack_timeout: got no ack_vld in 60 cycles, want one (sel %0d entry %0d)", sel, ent);
        end else begin
            if (memop) chk("ack_one_after_mem_ack", ack_cyc, mack_cyc + 1);
            else       chk("ack_latency_1", ack_cyc, rq_cyc + 1);
            if (chk_lit) chk("rd_data_literal", got, lit);
        end
        chk("mem_req_count", mreq_cnt - m0, memop);
        if (memop) begin
            chk("mem_op_write", last_wr, wr);
            chk("mem_entry", last_addr, ent);
            if (wr) chk("mem_wr_data", last_wdata, {mbuf[3], mbuf[2], mbuf[1], mbuf[0]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; soft_rst = 1'b0; req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        addr = '0; wr_data = '0;
        for (int k = 0; k < N; k++) mbuf[k] = '0;
        mem[0] = '0;
        mem[1] = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {ack_vld, rd_data, mem_req_vld, mem_wr_en, mem_rd_en, mem_addr}, '0);
        chk("reset_mem_wr_data", mem_wr_data, '0);
        rst = 1'b0;
        @(negedge clk);

        // Assemble an all-ones entry, commit over a pre-filled memory entry.
        do_req(1, 0, 3, 0, 32'hFFFF_FFFF, 1, 32'h0, 0);
        do_req(1, 0, 2, 0, 32'hFFFF_FFFF, 1, 32'h0, 0);
        do_req(1, 0, 1, 0, 32'hFFFF_FFFF, 1, 32'h0, 0);
        mem[0] = {16{8'hAA}};
        do_req(1, 0, 0, 0, 32'hFFFF_FFFF, 1, 32'h0, 0);
        chk("mem0_all_ones", mem[0], {MDW{1'b1}});

        // Snapshot read stays atomic after the memory changes.
        mem[1] = 128'h44444444_33333333_22222222_11111111;
        do_req(0, 1, 0, 1, 32'h0, 1, 32'h1111_1111, 0);
        mem[1] = {16{8'hAA}};
        do_req(0, 1, 1, 1, 32'h0, 1, 32'h2222_2222, 0);
        do_req(0, 1, 2, 1, 32'h0, 1, 32'h3333_3333, 0);
        do_req(0, 1, 3, 1, 32'h0, 1, 32'h4444_4444, 0);

        // Slow memory with a dropped request injected during the wait.
        mem_delay = 7;
        do_req(0, 1, 0, 1, 32'h0, 1, 32'hAAAA_AAAA, 3);
        mem_delay = 2;

        // Soft reset clears the assembly buffer.
        do_req(1, 0, 2, 0, 32'hDEAD_BEEF, 1, 32'h0, 0);
        do_req(1, 0, 3, 0, 32'hCAFE_F00D, 1, 32'h0, 0);
        @(negedge clk); soft_rst = 1'b1;
        @(negedge clk); soft_rst = 1'b0;
        for (int k = 0; k < N; k++) mbuf[k] = '0;
        do_req(1, 0, 0, 0, 32'h1234_5678, 1, 32'h0, 0);
        chk("mem0_upper_zero", mem[0], 128'h00000000_00000000_00000000_12345678);

        // Reset while a fetch is outstanding, then a stray memory ack.
        mem_auto = 1'b0;
        @(negedge clk);
        req_vld = 1'b1; wr_en = 1'b0; rd_en = 1'b1; addr = mk_addr(1, 0);
        @(negedge clk);
        req_vld = 1'b0; rd_en = 1'b0;
        chk("fetch_issued", {mem_req_vld, mem_rd_en, mem_addr}, 3'b111);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rst_clears_outputs", {ack_vld, mem_req_vld, mem_addr}, '0);
        rst = 1'b0;
        stray = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_ack_after_rst", ack_vld, '0);
        end
        mem_auto = 1'b1;
        for (int k = 0; k < N; k++) mbuf[k] = '0;
        do_req(0, 1, 0, 1, 32'h0, 1, 32'hAAAA_AAAA, 0);
        do_req(0, 1, 2, 1, 32'h0, 1, 32'hAAAA_AAAA, 0);

        // Qualifier corner cases.
        do_req(1, 1, 1, 0, 32'h5A5A_5A5A, 1, 32'h0, 0);
        do_req(0, 0, 1, 0, 32'h0, 1, 32'h0, 0);
        do_req(0, 1, 1, 0, 32'h0, 1, 32'h5A5A_5A5A, 0);

        repeat (4) @(negedge clk);
        chk("no_pending_acks", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
